// File: rtl/flag_order_ctrl.sv
// Flag-order selection controller: two players each step through four order codes
// and lock them in, with frame-synchronous display updates, a HUD blink and a selection timeout.
module flag_order_ctrl #(
   parameter int BLINK_FRAMES   = 30,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       p1_next,
   input  logic       p2_next,
   input  logic       p1_confirm,
   input  logic       p2_confirm,
   input  logic       round_reset,
   output logic [1:0] p1_order,
   output logic [1:0] p2_order,
   output logic       p1_locked,
   output logic       p2_locked,
   output logic       both_locked,
   output logic       hud_blink
);

   typedef enum logic {SELECT, LOCKED} player_t;
   typedef enum logic [1:0] {PICK, WAIT, READY} phase_t;

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_FRAMES - 1);
   localparam logic [9:0] BLK_LAST = 10'(BLINK_FRAMES - 1);

   player_t    p1_st, p1_st_nxt, p2_st, p2_st_nxt;
   phase_t     phase, phase_nxt;
   logic [1:0] p1_pend, p1_pend_nxt, p2_pend, p2_pend_nxt;
   logic [1:0] p1_order_nxt, p2_order_nxt;
   logic [9:0] tmo_cnt, tmo_cnt_nxt, blk_cnt, blk_cnt_nxt;
   logic       hud_nxt;
   logic       timeout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_st       <= SELECT;
         p2_st       <= SELECT;
         phase       <= PICK;
         p1_pend     <= '0;
         p2_pend     <= '0;
         p1_order    <= '0;
         p2_order    <= '0;
         tmo_cnt     <= '0;
         blk_cnt     <= '0;
         hud_blink   <= 1'b0;
         p1_locked   <= 1'b0;
         p2_locked   <= 1'b0;
         both_locked <= 1'b0;
      end else begin
         p1_st       <= p1_st_nxt;
         p2_st       <= p2_st_nxt;
         phase       <= phase_nxt;
         p1_pend     <= p1_pend_nxt;
         p2_pend     <= p2_pend_nxt;
         p1_order    <= p1_order_nxt;
         p2_order    <= p2_order_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         blk_cnt     <= blk_cnt_nxt;
         hud_blink   <= hud_nxt;
         p1_locked   <= (p1_st_nxt == LOCKED);
         p2_locked   <= (p2_st_nxt == LOCKED);
         both_locked <= (phase_nxt == READY);
      end
   end

   always_comb begin
      p1_st_nxt    = p1_st;
      p2_st_nxt    = p2_st;
      phase_nxt    = phase;
      p1_pend_nxt  = p1_pend;
      p2_pend_nxt  = p2_pend;
      p1_order_nxt = p1_order;
      p2_order_nxt = p2_order;
      tmo_cnt_nxt  = tmo_cnt;
      blk_cnt_nxt  = blk_cnt;
      hud_nxt      = hud_blink;
      timeout_hit  = frame_start && (phase != READY) && (tmo_cnt == TMO_LAST);

      if (round_reset) begin
         p1_st_nxt    = SELECT;
         p2_st_nxt    = SELECT;
         phase_nxt    = PICK;
         p1_pend_nxt  = '0;
         p2_pend_nxt  = '0;
         p1_order_nxt = '0;
         p2_order_nxt = '0;
         tmo_cnt_nxt  = '0;
         blk_cnt_nxt  = '0;
         hud_nxt      = 1'b0;
      end else begin
         // Visible codes take the pre-edge pending value, so a same-cycle next shows a frame later.
         if (frame_start) begin
            p1_order_nxt = p1_pend;
            p2_order_nxt = p2_pend;
         end

         unique case (p1_st)
            SELECT: begin
               if (p1_confirm || timeout_hit) p1_st_nxt = LOCKED;
               else if (p1_next)              p1_pend_nxt = p1_pend + 2'd1;
            end
            LOCKED: ;
         endcase

         unique case (p2_st)
            SELECT: begin
               if (p2_confirm || timeout_hit) p2_st_nxt = LOCKED;
               else if (p2_next)              p2_pend_nxt = p2_pend + 2'd1;
            end
            LOCKED: ;
         endcase

         unique case (phase)
            PICK, WAIT: begin
               if (p1_st_nxt == LOCKED && p2_st_nxt == LOCKED)    phase_nxt = READY;
               else if (p1_st_nxt == LOCKED || p2_st_nxt == LOCKED) phase_nxt = WAIT;
               else                                                 phase_nxt = PICK;
            end
            READY: phase_nxt = READY;
            default: phase_nxt = PICK;
         endcase

         if (phase_nxt == READY) begin
            tmo_cnt_nxt = '0;
            blk_cnt_nxt = '0;
            hud_nxt     = 1'b0;
         end else if (frame_start) begin
            tmo_cnt_nxt = tmo_cnt + 10'd1;
            if (blk_cnt == BLK_LAST) begin
               blk_cnt_nxt = '0;
               hud_nxt     = ~hud_blink;
            end else begin
               blk_cnt_nxt = blk_cnt + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_flag_order_ctrl.sv
// Randomized and directed bench for flag_order_ctrl against a per-player array model.
module tb_flag_order_ctrl;

   localparam int TO = 4;
   localparam int BL = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0, round_reset = 1'b0;
   logic       p1_next = 1'b0, p2_next = 1'b0, p1_confirm = 1'b0, p2_confirm = 1'b0;
   logic [1:0] p1_order, p2_order;
   logic       p1_locked, p2_locked, both_locked, hud_blink;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 0;

   // Reference model: plain integers per player.
   int m_pend[2];
   int m_vis[2];
   bit m_lock[2];
   int m_tcnt, m_bcnt;
   bit m_blink;

   flag_order_ctrl #(.BLINK_FRAMES(BL), .TIMEOUT_FRAMES(TO)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .p1_next(p1_next), .p2_next(p2_next),
      .p1_confirm(p1_confirm), .p2_confirm(p2_confirm),
      .round_reset(round_reset),
      .p1_order(p1_order), .p2_order(p2_order),
      .p1_locked(p1_locked), .p2_locked(p2_locked),
      .both_locked(both_locked), .hud_blink(hud_blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int p = 0; p < 2; p++) begin
         m_pend[p] = 0;
         m_vis[p]  = 0;
         m_lock[p] = 0;
      end
      m_tcnt = 0;
      m_bcnt = 0;
      m_blink = 0;
   endtask

   task automatic model_step(input bit rr, input bit fs, input bit nx1, input bit nx2,
                             input bit cf1, input bit cf2);
      bit nx[2];
      bit cf[2];
      bit hit;
      nx[0] = nx1; nx[1] = nx2; cf[0] = cf1; cf[1] = cf2;
      if (rr) begin
         model_clear();
         return;
      end
      hit = fs && !(m_lock[0] && m_lock[1]) && (m_tcnt == TO - 1);
      for (int p = 0; p < 2; p++) begin
         if (fs) m_vis[p] = m_pend[p];
         if (!m_lock[p]) begin
            if (cf[p] || hit) m_lock[p] = 1;
            else if (nx[p])   m_pend[p] = (m_pend[p] + 1) % 4;
         end
      end
      if (m_lock[0] && m_lock[1]) begin
         m_tcnt = 0;
         m_bcnt = 0;
         m_blink = 0;
      end else if (fs) begin
         m_tcnt++;
         if (m_bcnt == BL - 1) begin
            m_bcnt = 0;
            m_blink = !m_blink;
         end else begin
            m_bcnt++;
         end
      end
   endtask

   task automatic cyc(input bit rr, input bit fs, input bit nx1, input bit nx2,
                      input bit cf1, input bit cf2);
      round_reset = rr; frame_start = fs;
      p1_next = nx1; p2_next = nx2; p1_confirm = cf1; p2_confirm = cf2;
      @(posedge clk);
      model_step(rr, fs, nx1, nx2, cf1, cf2);
      #2;
      round_reset = 0; frame_start = 0;
      p1_next = 0; p2_next = 0; p1_confirm = 0; p2_confirm = 0;
   endtask

   task automatic async_reset();
      #1 rst = 1'b1;
      model_clear();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check("p1_order",    int'(p1_order),    m_vis[0]);
         check("p2_order",    int'(p2_order),    m_vis[1]);
         check("p1_locked",   int'(p1_locked),   int'(m_lock[0]));
         check("p2_locked",   int'(p2_locked),   int'(m_lock[1]));
         check("both_locked", int'(both_locked), int'(m_lock[0] && m_lock[1]));
         check("hud_blink",   int'(hud_blink),   int'(m_blink));
      end
   end

   initial begin
      model_clear();
      #1 check("rst_p1_order", int'(p1_order), 0);
      check("rst_both", int'(both_locked), 0);
      check("rst_hud", int'(hud_blink), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      checking = 1;

      // Five nexts then a frame: code 1 becomes visible.
      repeat (5) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_next5_p1_order", int'(p1_order), 1);
      check("d_next5_p2_order", int'(p2_order), 0);
      check("d_next5_p1_locked", int'(p1_locked), 0);

      // Next coinciding with frame shows the old pending value first.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0);
      #1 check("d_fs_next_p2_a", int'(p2_order), 0);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_fs_next_p2_b", int'(p2_order), 1);

      // Confirm wins over a simultaneous next; locked player ignores next.
      cyc(1, 0, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0);
      #1 check("d_lock_p1_locked", int'(p1_locked), 1);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_lock_p1_order", int'(p1_order), 2);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_lock_p1_hold", int'(p1_order), 2);
      check("d_wait_both", int'(both_locked), 0);
      cyc(0, 0, 0, 0, 0, 1);
      #1 check("d_ready_both", int'(both_locked), 1);
      check("d_ready_hud", int'(hud_blink), 0);
      cyc(1, 0, 0, 0, 0, 0);
      #1 check("d_rr_p1_order", int'(p1_order), 0);
      check("d_rr_p1_locked", int'(p1_locked), 0);
      check("d_rr_both", int'(both_locked), 0);

      // Timeout after TO frames, blink toggles after BL frames.
      for (int f = 1; f <= TO; f++) begin
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0);
         if (f == 1) #1 check("d_to_hud_f1", int'(hud_blink), 0);
         if (f == 2) #1 check("d_to_hud_f2", int'(hud_blink), 1);
      end
      #1 check("d_to_both", int'(both_locked), 1);
      check("d_to_p2_locked", int'(p2_locked), 1);
      check("d_to_hud_ready", int'(hud_blink), 0);

      // round_reset beats confirm and frame in the same cycle.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0);
      #1 check("d_rr_win_locked", int'(p1_locked), 0);
      check("d_rr_win_order", int'(p1_order), 0);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_rr_win_hud1", int'(hud_blink), 0);
      cyc(0, 1, 0, 0, 0, 0);
      #1 check("d_rr_win_hud2", int'(hud_blink), 1);

      // Asynchronous reset mid-selection.
      cyc(0, 0, 1, 0, 1, 0);
      async_reset();
      #1 check("d_arst_p1_locked", int'(p1_locked), 0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            async_reset();
         end else begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
         end
      end

      @(negedge clk);
      #1 checking = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
